// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the 4-bit ALU micro-sequencer.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD      = 4'h0;
   localparam logic [3:0] OP_ADC      = 4'h1;
   localparam logic [3:0] OP_SUB      = 4'h2;
   localparam logic [3:0] OP_SBC      = 4'h3;
   localparam logic [3:0] OP_AND      = 4'h4;
   localparam logic [3:0] OP_OR       = 4'h5;
   localparam logic [3:0] OP_XOR      = 4'h6;
   localparam logic [3:0] OP_NOT      = 4'h7;
   localparam logic [3:0] OP_SHL      = 4'h8;
   localparam logic [3:0] OP_SHR      = 4'h9;
   localparam logic [3:0] OP_INC      = 4'hA;
   localparam logic [3:0] OP_NAND_NOR = 4'hB;
   localparam logic [3:0] OP_LDI      = 4'hC;
   localparam logic [3:0] OP_MOV      = 4'hD;
   localparam logic [3:0] OP_CLRF     = 4'hE;
   localparam logic [3:0] OP_NOP      = 4'hF;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   localparam int unsigned FLAG_C  = 0;
   localparam int unsigned FLAG_B  = 1;
   localparam int unsigned FLAG_Z  = 2;
   localparam int unsigned FLAG_LT = 3;

   localparam logic [3:0] ALU_IDLE_MODE = 4'b1111;

   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= OP_NAND_NOR;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x4 register file: two operand ports captured on accept, one write port, one combinational debug read.
module alu_regfile #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [REG_AW-1:0] ra_addr,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_q,
   output logic [DATA_W-1:0] rb_q,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int unsigned NREG = 1 << REG_AW;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [DATA_W-1:0] ra_d, rb_d;

   always_comb begin
      regs_d = regs_q;
      ra_d   = ra_q;
      rb_d   = rb_q;
      if (we) regs_d[wa] = wd;
      if (rd_en) begin
         ra_d = regs_q[ra_addr];
         rb_d = regs_q[rb_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
         ra_q   <= '0;
         rb_q   <= '0;
      end else begin
         regs_q <= regs_d;
         ra_q   <= ra_d;
         rb_q   <= rb_d;
      end
   end

   assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_seq.sv
// Micro-sequencer: accepts one instruction, drives the external ALU for one cycle, then writes back.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [11:0]       instr_data,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_mode,
   output logic              alu_carry_f,
   output logic              alu_borrow_f,
   input  logic [DATA_W-1:0] alu_c,
   input  logic [3:0]        alu_flags,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags_q,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] c_q, c_d;
   logic [3:0]        aflags_q, aflags_d;
   logic [3:0]        flags_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              accept, we;
   logic [DATA_W-1:0] wd;

   alu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (accept),
      .ra_addr  (instr_data[7:6]),
      .rb_addr  (instr_data[5:4]),
      .ra_q     (alu_a),
      .rb_q     (alu_b),
      .we       (we),
      .wa       (rd_q),
      .wd       (wd),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      c_d         = c_q;
      aflags_d    = aflags_q;
      flags_d     = flags_q;
      result_d    = result_q;
      accept      = 1'b0;
      we          = 1'b0;
      wd          = c_q;
      instr_ready = 1'b0;
      done        = 1'b0;
      alu_mode    = ALU_IDLE_MODE;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               accept  = 1'b1;
               op_d    = instr_data[11:8];
               rd_d    = instr_data[7:6];
               imm_d   = instr_data[3:0];
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_mode = is_alu_op(op_q) ? op_q : ALU_IDLE_MODE;
            c_d      = alu_c;
            aflags_d = alu_flags;
            state_d  = WB;
         end
         WB: begin
            done    = 1'b1;
            state_d = IDLE;
            // Carry and borrow are sticky: only ADC/SBC may change them.
            if (is_alu_op(op_q)) begin
               we               = 1'b1;
               wd               = c_q;
               flags_d[FLAG_LT] = aflags_q[FLAG_LT];
               flags_d[FLAG_Z]  = aflags_q[FLAG_Z];
               if (op_q == OP_ADC) flags_d[FLAG_C] = aflags_q[FLAG_C];
               if (op_q == OP_SBC) flags_d[FLAG_B] = aflags_q[FLAG_B];
            end else if (op_q == OP_LDI) begin
               we = 1'b1;
               wd = imm_q;
            end else if (op_q == OP_MOV) begin
               we = 1'b1;
               wd = alu_b;
            end else if (op_q == OP_CLRF) begin
               flags_d[FLAG_B] = 1'b0;
               flags_d[FLAG_C] = 1'b0;
            end
            if (we) result_d = wd;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         c_q      <= '0;
         aflags_q <= '0;
         flags_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         imm_q    <= imm_d;
         c_q      <= c_d;
         aflags_q <= aflags_d;
         flags_q  <= flags_d;
         result_q <= result_d;
      end
   end

   assign result       = result_q;
   assign alu_carry_f  = flags_q[FLAG_C];
   assign alu_borrow_f = flags_q[FLAG_B];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural ALU stub and an instruction-level reference model.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [11:0] instr_data = '0;
   logic        instr_ready;
   logic [3:0]  alu_a, alu_b, alu_mode, alu_c, alu_flags;
   logic        alu_carry_f, alu_borrow_f;
   logic        done;
   logic [3:0]  result, flags_q;
   logic [1:0]  dbg_sel = '0;
   logic [3:0]  dbg_data;

   alu_seq #(.DATA_W(4), .REG_AW(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_data   (instr_data),
      .instr_ready  (instr_ready),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_mode     (alu_mode),
      .alu_carry_f  (alu_carry_f),
      .alu_borrow_f (alu_borrow_f),
      .alu_c        (alu_c),
      .alu_flags    (alu_flags),
      .done         (done),
      .result       (result),
      .flags_q      (flags_q),
      .dbg_sel      (dbg_sel),
      .dbg_data     (dbg_data)
   );

   always #5 clk = ~clk;

   // Arithmetic behaviour of the external 4-bit ALU: returns {flags, result}.
   function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                          input logic cin, input logic bin);
      int s;
      logic [3:0] r;
      logic c, bo, lt;
      s = 0; r = '0; c = 1'b0; bo = 1'b0; lt = 1'b0;
      case (op)
         4'h0: begin s = int'(a) + int'(b); r = 4'(s); c = (s > 15); end
         4'h1: begin s = int'(a) + int'(b) + int'(cin); r = 4'(s); c = (s > 15); end
         4'h2: begin s = int'(a) - int'(b); r = 4'(s); bo = (s < 0); lt = (a < b); end
         4'h3: begin s = int'(a) - int'(b) - int'(bin); r = 4'(s); bo = (s < 0); lt = (a < b); end
         4'h4: r = a & b;
         4'h5: r = a | b;
         4'h6: r = a ^ b;
         4'h7: r = ~a;
         4'h8: begin r = {a[2:0], 1'b0}; c = a[3]; end
         4'h9: begin r = {1'b0, a[3:1]}; c = a[0]; end
         4'hA: begin s = int'(a) + 1; r = 4'(s); c = (s > 15); end
         4'hB: r = ~(a & b);
         default: r = '0;
      endcase
      return {lt, (r == 4'h0), bo, c, r};
   endfunction

   always_comb {alu_flags, alu_c} = alu_ref(alu_mode, alu_a, alu_b, alu_carry_f, alu_borrow_f);

   typedef struct {
      logic [1:0]  rd;
      logic [3:0]  rval;
      logic [3:0]  result;
      logic [3:0]  flags;
      int unsigned acc;
   } exp_t;

   exp_t        sb[$];
   logic [3:0]  m_regs [4];
   logic [3:0]  m_flags, m_result;
   int unsigned n_checks = 0, n_pass = 0, n_done = 0, cyc = 0;
   bit          mon_busy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: got event-timeout expected completion (t=%0t)", name, $time);
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_flags  = '0;
      m_result = '0;
   endfunction

   function automatic void model_step(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                      input logic [3:0] imm);
      logic [7:0] fr;
      if (op <= 4'hB) begin
         fr = alu_ref(op, m_regs[rd], m_regs[rs], m_flags[0], m_flags[1]);
         m_regs[rd]   = fr[3:0];
         m_result     = fr[3:0];
         m_flags[3:2] = fr[7:6];
         if (op == 4'h1) m_flags[0] = fr[4];
         if (op == 4'h3) m_flags[1] = fr[5];
      end else if (op == 4'hC) begin
         m_regs[rd] = imm;
         m_result   = imm;
      end else if (op == 4'hD) begin
         m_regs[rd] = m_regs[rs];
         m_result   = m_regs[rs];
      end else if (op == 4'hE) begin
         m_flags[1:0] = 2'b00;
      end
   endfunction

   task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [3:0] imm, input bit hold);
      exp_t        e;
      int unsigned w;
      logic [3:0]  ea, eb, emode;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_data  = {op, rd, rs, imm};
      w = 0;
      while (!instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!instr_ready) begin
         fail_now("accept_timeout");
         instr_valid = 1'b0;
         return;
      end
      ea    = m_regs[rd];
      eb    = m_regs[rs];
      emode = (op <= 4'hB) ? op : 4'hF;
      model_step(op, rd, rs, imm);
      e.rd = rd; e.rval = m_regs[rd]; e.result = m_result; e.flags = m_flags; e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) instr_valid = 1'b0;
      chk("exec_ready_low", instr_ready, 0);
      chk("exec_mode", alu_mode, emode);
      chk("exec_alu_a", alu_a, ea);
      chk("exec_alu_b", alu_b, eb);
   endtask

   task automatic drain();
      int unsigned w;
      w = 0;
      while ((sb.size() != 0 || mon_busy) && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0 || mon_busy) fail_now("drain_timeout");
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      model_clear();
      #1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_mode", alu_mode, 4'hF);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags_q, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", instr_ready, 1);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = i[1:0];
         #1;
         chk("rst_reg", dbg_data, 0);
      end
   endtask

   task automatic expect_reg(input string name, input logic [1:0] idx, input logic [3:0] val);
      dbg_sel = idx;
      #1;
      chk(name, dbg_data, val);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
            end else begin
               mon_busy = 1'b1;
               e = sb.pop_front();
               chk("done_latency", cyc, e.acc + 2);
               chk("wb_ready_low", instr_ready, 0);
               dbg_sel = e.rd;
               @(negedge clk);
               chk("done_width", done, 0);
               chk("result", result, e.result);
               chk("flags", flags_q, e.flags);
               chk("reg_wb", dbg_data, e.rval);
               mon_busy = 1'b0;
            end
         end
      end
   end

   initial begin : stimulus
      int unsigned n0;
      model_clear();
      do_reset();

      for (int i = 0; i < 40; i++)
         send(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 4'($urandom), 1'b0);
      drain();

      // Reset in the middle of a run
      do_reset();

      // ADC with carry-out, then carry-in
      send(4'hC, 2'd1, 2'd0, 4'h9, 1'b0);
      send(4'hC, 2'd2, 2'd0, 4'h8, 1'b0);
      send(4'h1, 2'd1, 2'd2, 4'h0, 1'b0);
      drain();
      expect_reg("adc1_r1", 2'd1, 4'h1);
      chk("adc1_flags", flags_q, 4'b0001);
      send(4'h1, 2'd1, 2'd2, 4'h0, 1'b0);
      drain();
      expect_reg("adc2_r1", 2'd1, 4'hA);
      chk("adc2_flags", flags_q, 4'b0000);

      // SBC with borrow, then CLRF
      send(4'hC, 2'd0, 2'd0, 4'h3, 1'b0);
      send(4'hC, 2'd3, 2'd0, 4'h5, 1'b0);
      send(4'h3, 2'd0, 2'd3, 4'h0, 1'b0);
      drain();
      expect_reg("sbc_r0", 2'd0, 4'hE);
      chk("sbc_flags", flags_q, 4'b1010);
      send(4'hE, 2'd0, 2'd0, 4'h0, 1'b0);
      drain();
      chk("clrf_flags", flags_q, 4'b1000);
      expect_reg("clrf_r0", 2'd0, 4'hE);

      // rd == rs uses pre-write operands
      send(4'hC, 2'd2, 2'd0, 4'hA, 1'b0);
      send(4'h6, 2'd2, 2'd2, 4'h0, 1'b0);
      drain();
      expect_reg("xor_r2", 2'd2, 4'h0);
      chk("xor_flags", flags_q, 4'b0100);
      chk("xor_result", result, 4'h0);

      // instr_valid held high across two instructions
      n0 = n_done;
      send(4'hC, 2'd3, 2'd0, 4'h6, 1'b1);
      send(4'hD, 2'd0, 2'd3, 4'h0, 1'b0);
      drain();
      chk("held_valid_done_count", n_done - n0, 2);
      expect_reg("held_mov_r0", 2'd0, 4'h6);

      // Reset during EXEC aborts the instruction
      send(4'hC, 2'd0, 2'd0, 4'h7, 1'b0);
      drain();
      send(4'h0, 2'd0, 2'd0, 4'h0, 1'b0);
      n0 = n_done;
      do_reset();
      repeat (6) @(negedge clk);
      chk("abort_no_done", n_done - n0, 0);
      expect_reg("abort_r0", 2'd0, 4'h0);

      for (int i = 0; i < 150; i++)
         send(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 4'($urandom),
              (i != 149) && ($urandom_range(0, 3) == 0));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
